axum_bus_copier: RTL and testbench
==================================

Name: axum_bus_copier

Overview:
- Word-granular memory-copy engine that acts as the initiator on the axum peripheral/memory bus (req/addr/we/be/wdata -> rvalid/rdata/err).
- Copies len_i 32-bit words from src_addr_i to dst_addr_i using one bus read, then one bus write, per word.
- Sits beside the core as a second bus master. It drives responders that sample req in cycle N and return rvalid/rdata/err in cycle N+1, for example GPIO, timer and RAM.
- Reports completion, progress and abort cause to the control side.

Parameters:
- DataWidth, 32, bus data width; only 32 is supported.
- AddressWidth, 32, bus address width.
- LenWidth, 16, width of the word-count input and progress counter.
- TimeoutCycles, 16, wait-state cycles allowed for rvalid before abort; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- src_addr_i  in  AddressWidth  source byte address; bits [1:0] are ignored (forced 0).
- dst_addr_i  in  AddressWidth  destination byte address; bits [1:0] are ignored.
- len_i  in  LenWidth  number of words to copy.
- busy_o  out  1  high while not in IDLE.
- done_o  out  1  one-cycle pulse at the end of a transfer, on success or abort.
- err_o  out  1  sticky abort flag; cleared on the next accepted start.
- err_timeout_o  out  1  sticky; the abort cause was a timeout, not bus_err_i.
- err_addr_o  out  AddressWidth  address of the failing access.
- words_done_o  out  LenWidth  number of words fully written.
- bus_req_o  out  1  request strobe.
- bus_addr_o  out  AddressWidth  request address.
- bus_we_o  out  1  1 = write, 0 = read.
- bus_be_o  out  DataWidth/8  byte enables; always 4'hF on both read and write.
- bus_wdata_o  out  DataWidth  write data.
- bus_rvalid_i  in  1  response valid.
- bus_rdata_i  in  DataWidth  read data; valid with bus_rvalid_i on reads.
- bus_err_i  in  1  error; valid with bus_rvalid_i.

Behaviour:
- Reset (rst_ni low at a clock edge, synchronous, active-low):
  - state goes to IDLE;
  - all outputs go to 0: busy_o, done_o, err_o, err_timeout_o, err_addr_o, words_done_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o;
  - bus_be_o is 0 during reset;
  - reset mid-transfer abandons the transfer with no done_o pulse;
  - a late rvalid arriving after reset is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - On start_i, latch src, dst and len into internal registers, then clear err_o, err_timeout_o, err_addr_o and words_done_o.
  - If len = 0, go to FIN; otherwise go to RD_REQ.
  - start_i in any other state is ignored; inputs are not re-sampled mid-transfer.
- RD_REQ:
  - Assert bus_req_o=1, bus_we_o=0, bus_addr_o=src for exactly one cycle.
  - Clear the wait counter; go to RD_WAIT.
- RD_WAIT:
  - bus_req_o=0.
  - rvalid with err=0: capture rdata into the data register; go to WR_REQ.
  - rvalid with err=1: abort.
  - No rvalid: increment the wait counter; when it reaches TimeoutCycles, abort with a timeout.
- WR_REQ:
  - Assert bus_req_o=1, bus_we_o=1, bus_addr_o=dst, bus_wdata_o=data register for one cycle; go to WR_WAIT.
- WR_WAIT:
  - Same response and timeout rules as RD_WAIT.
  - On success: src += 4, dst += 4, words_done_o += 1, remaining -= 1.
  - Go to FIN if remaining reaches 0; otherwise go to RD_REQ.
- FIN: done_o=1 for one cycle, then go to IDLE; busy_o stays 1 during FIN.
- Abort:
  - err_o=1; err_addr_o = address of the failing access; err_timeout_o set if the cause was a timeout.
  - Go to FIN.
  - words_done_o excludes the failed word.
- rvalid in RD_REQ, WR_REQ, IDLE or FIN is ignored, not an error.
- Address arithmetic is modulo 2^AddressWidth; wrap-around past the top is silent.
- Bus outputs are registered. bus_addr_o and bus_wdata_o hold their last values while bus_req_o=0.
- Latency with a zero-wait responder, start sampled at cycle T:
  - first bus_req_o at T+1;
  - 4 cycles per word;
  - done_o at T+4*len+1;
  - len=0 gives done_o at T+1.

Decomposition:
- Shared package axum_bus_pkg holds:
  - the state enum bus_copier_state_e;
  - constant BUS_WORD_BYTES=4;
  - constant BUS_BE_ALL=4'hF.
- One natural sub-module, axum_bus_timeout, the wait counter:
  - inputs clear and enable;
  - output expired, with parameter TimeoutCycles.
- Everything else stays in one module.

Test Plan:
- Basic copy: RAM model with 1-cycle response; src=0x100 holds words 0xA0,0xA1,0xA2; dst=0x200; len=3.
  - Expect: reads 0x100/0x104/0x108 and writes 0x200/0x204/0x208 with those data and be=4'hF.
  - Expect: done_o pulse exactly 13 cycles after start; words_done_o=3; err_o=0.
- Zero length: len=0 -> no bus_req_o; done_o one cycle after start; busy_o high for exactly 1 cycle.
- Bus error: bus_err_i=1 on the 2nd read of a 4-word copy from src=0x40.
  - Expect: err_o=1, err_timeout_o=0, err_addr_o=0x44, words_done_o=1, done_o pulses; no write to the 2nd destination word.
- Timeout: responder never returns rvalid, TimeoutCycles=16.
  - Expect: abort 16 cycles after the first RD_WAIT cycle; err_o=1, err_timeout_o=1, err_addr_o=src; done_o pulse.
  - A following start with a good responder clears err_o and err_timeout_o.
- Wrap and ignore: src=0xFFFF_FFFC, len=2.
  - Expect: second read at 0x0000_0000.
  - start_i re-pulsed mid-transfer with different inputs has no effect.
- Reset mid-op: deassert rst_ni during WR_WAIT.
  - Expect: next cycle all outputs 0, state IDLE, no done_o; a stray rvalid afterwards is ignored.

Source files
------------

// File: rtl/axum_bus_pkg.sv
// Shared definitions for the axum bus copier.
//   bus_copier_state_e : copier FSM state encoding
//   BUS_WORD_BYTES     : byte stride between consecutive bus words
//   BUS_BE_ALL         : full-word byte-enable mask
package axum_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_FIN
  } bus_copier_state_e;

  localparam int unsigned BUS_WORD_BYTES = 4;
  localparam logic [3:0]  BUS_BE_ALL     = 4'hF;

endpackage

// File: rtl/axum_bus_timeout.sv
// Wait-state counter for the bus copier.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : restart the count (issued while the request is on the bus)
//   enable_i      : a wait cycle without a response
//   expired_o     : this wait cycle is the TimeoutCycles-th one without a response
module axum_bus_timeout #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // The count holds the number of wait cycles already spent, so the
  // cycle that would bring it to TimeoutCycles is reported directly.
  assign expired_o = enable_i && (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axum_bus_copier.sv
// Word-granular memory-copy engine, initiator on the axum bus.
// Copies len_i words from src_addr_i to dst_addr_i, one read then one write
// per word, against responders that answer one cycle after the request.
//   control : start_i, src_addr_i, dst_addr_i, len_i
//   status  : busy_o, done_o, err_o, err_timeout_o, err_addr_o, words_done_o
//   bus     : bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o (registered)
//             bus_rvalid_i, bus_rdata_i, bus_err_i
module axum_bus_copier #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [AddressWidth-1:0]   src_addr_i,
  input  logic [AddressWidth-1:0]   dst_addr_i,
  input  logic [LenWidth-1:0]       len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      err_timeout_o,
  output logic [AddressWidth-1:0]   err_addr_o,
  output logic [LenWidth-1:0]       words_done_o,
  output logic                      bus_req_o,
  output logic [AddressWidth-1:0]   bus_addr_o,
  output logic                      bus_we_o,
  output logic [DataWidth/8-1:0]    bus_be_o,
  output logic [DataWidth-1:0]      bus_wdata_o,
  input  logic                      bus_rvalid_i,
  input  logic [DataWidth-1:0]      bus_rdata_i,
  input  logic                      bus_err_i
);

  import axum_bus_pkg::*;

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam logic [AddressWidth-1:0] AddrStep = AddressWidth'(BUS_WORD_BYTES);

  bus_copier_state_e state_q, state_d;

  logic [AddressWidth-1:0] src_q, src_d;
  logic [AddressWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]     rem_q, rem_d;
  logic [LenWidth-1:0]     words_done_q, words_done_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    err_timeout_q, err_timeout_d;
  logic [AddressWidth-1:0] err_addr_q, err_addr_d;
  logic                    bus_req_q, bus_req_d;
  logic [AddressWidth-1:0] bus_addr_q, bus_addr_d;
  logic                    bus_we_q, bus_we_d;
  logic [BeWidth-1:0]      bus_be_q, bus_be_d;
  logic [DataWidth-1:0]    bus_wdata_q, bus_wdata_d;

  logic [AddressWidth-1:0] src_aligned, dst_aligned, src_next, dst_next;
  logic                    to_clear, to_enable, to_expired;
  logic                    abort;
  logic                    abort_timeout;
  logic [AddressWidth-1:0] abort_addr;
  logic                    unused_addr_lsbs;

  assign src_aligned      = {src_addr_i[AddressWidth-1:2], 2'b00};
  assign dst_aligned      = {dst_addr_i[AddressWidth-1:2], 2'b00};
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};
  assign src_next         = src_q + AddrStep;
  assign dst_next         = dst_q + AddrStep;

  assign to_clear  = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign to_enable = ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)) && !bus_rvalid_i;

  axum_bus_timeout #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (to_clear),
    .enable_i  (to_enable),
    .expired_o (to_expired)
  );

  // Bus outputs are computed from the next state so the request strobe
  // is high exactly during the RD_REQ/WR_REQ cycles. bus_wdata_q doubles
  // as the read-data holding register between the read and the write.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    rem_d          = rem_q;
    words_done_d   = words_done_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = err_q;
    err_timeout_d  = err_timeout_q;
    err_addr_d     = err_addr_q;
    bus_req_d      = 1'b0;
    bus_addr_d     = bus_addr_q;
    bus_we_d       = bus_we_q;
    bus_be_d       = BeWidth'(BUS_BE_ALL);
    bus_wdata_d    = bus_wdata_q;
    abort          = 1'b0;
    abort_timeout  = 1'b0;
    abort_addr     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d         = src_aligned;
          dst_d         = dst_aligned;
          rem_d         = len_i;
          err_d         = 1'b0;
          err_timeout_d = 1'b0;
          err_addr_d    = '0;
          words_done_d  = '0;
          busy_d        = 1'b1;
          if (len_i == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_RD_REQ;
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = src_aligned;
          end
        end
      end

      ST_RD_REQ: state_d = ST_RD_WAIT;

      ST_RD_WAIT: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            abort      = 1'b1;
            abort_addr = src_q;
          end else begin
            bus_wdata_d = bus_rdata_i;
            state_d     = ST_WR_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = dst_q;
          end
        end else if (to_expired) begin
          abort         = 1'b1;
          abort_timeout = 1'b1;
          abort_addr    = src_q;
        end
      end

      ST_WR_REQ: state_d = ST_WR_WAIT;

      ST_WR_WAIT: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            abort      = 1'b1;
            abort_addr = dst_q;
          end else begin
            src_d        = src_next;
            dst_d        = dst_next;
            words_done_d = words_done_q + LenWidth'(1);
            rem_d        = rem_q - LenWidth'(1);
            if (rem_q == LenWidth'(1)) begin
              state_d = ST_FIN;
              done_d  = 1'b1;
            end else begin
              state_d    = ST_RD_REQ;
              bus_req_d  = 1'b1;
              bus_we_d   = 1'b0;
              bus_addr_d = src_next;
            end
          end
        end else if (to_expired) begin
          abort         = 1'b1;
          abort_timeout = 1'b1;
          abort_addr    = dst_q;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      err_d         = 1'b1;
      err_timeout_d = abort_timeout;
      err_addr_d    = abort_addr;
      done_d        = 1'b1;
      state_d       = ST_FIN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      words_done_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_timeout_q <= 1'b0;
      err_addr_q    <= '0;
      bus_req_q     <= 1'b0;
      bus_addr_q    <= '0;
      bus_we_q      <= 1'b0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rem_q         <= rem_d;
      words_done_q  <= words_done_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_timeout_q <= err_timeout_d;
      err_addr_q    <= err_addr_d;
      bus_req_q     <= bus_req_d;
      bus_addr_q    <= bus_addr_d;
      bus_we_q      <= bus_we_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_timeout_o = err_timeout_q;
  assign err_addr_o    = err_addr_q;
  assign words_done_o  = words_done_q;
  assign bus_req_o     = bus_req_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_we_o      = bus_we_q;
  assign bus_be_o      = bus_be_q;
  assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: tb/tb_axum_bus_copier.sv
// Self-checking bench for axum_bus_copier: a table of copy jobs run against a
// one-cycle responder model, plus hand-written reset sequences.
module tb_axum_bus_copier;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o, err_timeout_o;
  logic [31:0] err_addr_o;
  logic [15:0] words_done_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  axum_bus_copier #(
    .DataWidth     (32),
    .AddressWidth  (32),
    .LenWidth      (16),
    .TimeoutCycles (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .src_addr_i    (src_addr_i),
    .dst_addr_i    (dst_addr_i),
    .len_i         (len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_timeout_o (err_timeout_o),
    .err_addr_o    (err_addr_o),
    .words_done_o  (words_done_o),
    .bus_req_o     (bus_req_o),
    .bus_addr_o    (bus_addr_o),
    .bus_we_o      (bus_we_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_err_i     (bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- responder model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  txn_t        log_q[$];
  logic        s_req = 1'b0, s_we = 1'b0;
  logic [31:0] s_addr = '0;
  bit          never = 0;
  bit          stray = 0;
  int          err_rd = 0, err_wr = 0, rd_cnt = 0, wr_cnt = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(negedge clk_i) begin
    s_req  = bus_req_o;
    s_we   = bus_we_o;
    s_addr = bus_addr_o;
    if (bus_req_o) log_q.push_back('{bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o});
  end

  always @(posedge clk_i) begin
    #1;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    bus_rdata_i  = '0;
    if (stray) begin
      bus_rvalid_i = 1'b1;
      bus_err_i    = 1'b1;
      bus_rdata_i  = 32'hBAD0_BAD0;
      stray        = 0;
    end else if (s_req && !never) begin
      bus_rvalid_i = 1'b1;
      if (!s_we) begin
        rd_cnt++;
        bus_rdata_i = rd_val(s_addr);
        bus_err_i   = (rd_cnt == err_rd);
      end else begin
        wr_cnt++;
        bus_err_i = (wr_cnt == err_wr);
      end
    end
  end

  // ---------------- job table ----------------
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    bit          never;
    int          err_rd;
    int          err_wr;
    int          repulse;
    int          exp_done;
    int          exp_busy;
    bit          exp_err;
    bit          exp_to;
    logic [31:0] exp_eaddr;
    int          exp_words;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int done_at, busy_cnt, done_cnt, ri, wi;
    logic [31:0] sa, da;
    string tag;
    tag = $sformatf("v%0d", idx);
    sa = {v.src[31:2], 2'b00};
    da = {v.dst[31:2], 2'b00};
    log_q.delete();
    never = v.never; err_rd = v.err_rd; err_wr = v.err_wr; rd_cnt = 0; wr_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1; src_addr_i = v.src; dst_addr_i = v.dst; len_i = v.len;
    @(negedge clk_i);
    start_i = 1'b0;
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      if (v.repulse != 0 && k == v.repulse) begin
        start_i = 1'b1; src_addr_i = 32'h0000_1234; dst_addr_i = 32'h0000_5678; len_i = 16'd7;
      end else begin
        start_i = 1'b0;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done_at >= 0 && !busy_o) break;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    check({tag, "_done_cycle"}, done_at, v.exp_done);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    check({tag, "_err"}, err_o, v.exp_err);
    check({tag, "_err_timeout"}, err_timeout_o, v.exp_to);
    check({tag, "_err_addr"}, err_addr_o, v.exp_eaddr);
    check({tag, "_words_done"}, words_done_o, v.exp_words);
    ri = 0; wi = 0;
    foreach (log_q[i]) begin
      check({tag, "_be"}, log_q[i].be, 4'hF);
      if (!log_q[i].we) begin
        check({tag, "_rd_addr"}, log_q[i].addr, sa + 32'(4 * ri));
        ri++;
      end else begin
        check({tag, "_wr_addr"}, log_q[i].addr, da + 32'(4 * wi));
        check({tag, "_wr_data"}, log_q[i].data, rd_val(sa + 32'(4 * wi)));
        wi++;
      end
    end
    check({tag, "_reads"}, ri, v.exp_reads);
    check({tag, "_writes"}, wi, v.exp_writes);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_err_timeout"}, err_timeout_o, 1'b0);
    check({tag, "_err_addr"}, err_addr_o, 32'h0);
    check({tag, "_words_done"}, words_done_o, 16'h0);
    check({tag, "_req"}, bus_req_o, 1'b0);
    check({tag, "_we"}, bus_we_o, 1'b0);
    check({tag, "_addr"}, bus_addr_o, 32'h0);
    check({tag, "_wdata"}, bus_wdata_o, 32'h0);
    check({tag, "_be"}, bus_be_o, 4'h0);
  endtask

  initial begin
    int flags;
    //            src           dst          len never rd wr rp done busy err to eaddr        wds rds wrs
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd3, 0, 0, 0, 0, 13, 13, 0, 0, 32'h0,         3, 3, 3};
    vecs[1] = '{32'h0000_0040, 32'h0000_0300, 16'd4, 0, 2, 0, 0,  7,  7, 1, 0, 32'h44,        1, 2, 1};
    vecs[2] = '{32'h0000_0500, 32'h0000_0600, 16'd2, 1, 0, 0, 0, 18, 18, 1, 1, 32'h500,       0, 1, 0};
    vecs[3] = '{32'h0000_0103, 32'h0000_0283, 16'd1, 0, 0, 0, 0,  5,  5, 0, 0, 32'h0,         1, 1, 1};
    vecs[4] = '{32'h0000_0100, 32'h0000_0700, 16'd0, 0, 0, 0, 0,  1,  1, 0, 0, 32'h0,         0, 0, 0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0800, 16'd2, 0, 0, 0, 3,  9,  9, 0, 0, 32'h0,         2, 2, 2};
    vecs[6] = '{32'h0000_0100, 32'h0000_0900, 16'd2, 0, 0, 1, 0,  5,  5, 1, 0, 32'h900,       0, 1, 1};

    rst_ni = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_be", bus_be_o, 4'hF);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while the first write is awaiting its response.
    log_q.delete(); never = 0; err_rd = 0; err_wr = 0; rd_cnt = 0; wr_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1; src_addr_i = 32'h100; dst_addr_i = 32'h200; len_i = 16'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midrst_pre_busy", busy_o, 1'b1);
    check("midrst_pre_we", bus_we_o, 1'b1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_all_zero("midrst");
    rst_ni = 1'b1;
    @(negedge clk_i);
    stray = 1;
    flags = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (busy_o || done_o || err_o || bus_req_o || (words_done_o != 16'h0)) flags++;
    end
    check("stray_rvalid_ignored", flags, 0);
    check("stray_err", err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
